// File: rtl/prog_loader_arbiter_if.sv
// Byte stream from the UART receiver into the program loader.
// The receiver side uses the master modport, the loader the slave modport.
interface prog_loader_arbiter_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );
endinterface

// File: rtl/prog_loader_arbiter.sv
// Program memory owner for the Brainfuck CPU.
// After reset (or an '@' command) the whole program RAM is cleared to NOP,
// then ASCII program text from the UART is translated to 4-bit opcodes and
// written sequentially until the terminator arrives. Afterwards the RAM port
// is handed to the CPU combinationally and the CPU is released from RESTART.
// Optional macro BRACKET_CHECK_EN: track '[' / ']' nesting during a load and
// park in a FAULT state instead of running an unbalanced program.
module prog_loader_arbiter #(
  parameter int         MEM_DEPTH  = 1024,
  parameter logic [7:0] TERM_CHAR  = 8'h21,
  parameter logic [7:0] START_CHAR = 8'h40,
  localparam int        AW         = $clog2(MEM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  prog_loader_arbiter_if.slave rx,
  input  logic [AW-1:0]        cpu_prog_address,
  input  logic [3:0]           cpu_prog_data,
  input  logic                 cpu_prog_wren,
  input  logic                 cpu_prog_rden,
  output logic [AW-1:0]        prog_address_sig,
  output logic [3:0]           prog_data_sig,
  output logic                 prog_wren_sig,
  output logic                 prog_rden_sig,
  output logic                 cpu_hold,
  output logic                 load_done,
  output logic                 load_error,
  output logic [AW-1:0]        prog_length
);

  // The top address is never loaded: the CPU halts when its pc reaches it,
  // so it must always hold a NOP.
  localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_DEPTH - 1);
  localparam logic [3:0]    OP_NOP    = 4'd0;

`ifdef BRACKET_CHECK_EN
  localparam logic [3:0] OP_LOOP_OPEN  = 4'd7;
  localparam logic [3:0] OP_LOOP_CLOSE = 4'd8;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FAULT = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;
`endif

  state_t state_reg;
  state_t state_next;

  // Registered Moore outputs
  logic rx_ready_reg;
  logic rx_ready_next;
  logic cpu_hold_reg;
  logic cpu_hold_next;
  logic load_done_reg;
  logic load_done_next;

  // Loader-side RAM write port and load bookkeeping
  logic [AW-1:0] addr_cnt_reg;
  logic [AW-1:0] wr_addr_reg;
  logic [3:0]    wr_data_reg;
  logic          wr_en_reg;
  logic          load_error_reg;
  logic [AW-1:0] prog_length_reg;
`ifdef BRACKET_CHECK_EN
  logic [9:0]    depth_reg;
`endif

  logic       accept;
  logic       is_term;
  logic       is_start;
  logic       op_valid;
  logic [3:0] op_code;
  logic       clear_done;
  logic       enter_clear;

  assign accept      = rx.rx_valid & rx_ready_reg;
  assign is_term     = accept & (rx.rx_data == TERM_CHAR);
  assign is_start    = accept & (rx.rx_data == START_CHAR);
  // The write of the top address is on the bus: the sweep is complete.
  assign clear_done  = wr_en_reg & (wr_addr_reg == LAST_ADDR);
  assign enter_clear = (state_next == ST_CLEAR) & (state_reg != ST_CLEAR);

  assign rx.rx_ready = rx_ready_reg;
  assign cpu_hold    = cpu_hold_reg;
  assign load_done   = load_done_reg;
  assign load_error  = load_error_reg;
  assign prog_length = prog_length_reg;

  // Translate the incoming ASCII character into an opcode
  always_comb begin
    op_code  = OP_NOP;
    op_valid = 1'b1;
    case (rx.rx_data)
      8'h3E:   op_code = 4'd1;  // '>'
      8'h3C:   op_code = 4'd2;  // '<'
      8'h2B:   op_code = 4'd3;  // '+'
      8'h2D:   op_code = 4'd4;  // '-'
      8'h2E:   op_code = 4'd5;  // '.'
      8'h2C:   op_code = 4'd6;  // ','
      8'h5B:   op_code = 4'd7;  // '['
      8'h5D:   op_code = 4'd8;  // ']'
      default: op_valid = 1'b0;
    endcase
  end

  // State register and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_CLEAR;
      rx_ready_reg  <= 1'b0;
      cpu_hold_reg  <= 1'b1;
      load_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      rx_ready_reg  <= rx_ready_next;
      cpu_hold_reg  <= cpu_hold_next;
      load_done_reg <= load_done_next;
    end
  end

  // Next-state selection
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_CLEAR: begin
        if (clear_done) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        if (is_term) begin
`ifdef BRACKET_CHECK_EN
          if ((depth_reg != '0) || load_error_reg) state_next = ST_FAULT;
          else                                     state_next = ST_RUN;
`else
          state_next = ST_RUN;
`endif
        end
      end
      ST_RUN: begin
        if (is_start) state_next = ST_CLEAR;
      end
`ifdef BRACKET_CHECK_EN
      ST_FAULT: begin
        if (is_start) state_next = ST_CLEAR;
      end
`endif
      default: state_next = ST_CLEAR;
    endcase
  end

  // Output values for the state being entered, so they register with it
  always_comb begin
    rx_ready_next  = (state_next != ST_CLEAR);
    cpu_hold_next  = (state_next != ST_RUN);
    load_done_next = (state_next == ST_RUN);
  end

  // Clear sweep, opcode writes and load bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_cnt_reg    <= '0;
      wr_addr_reg     <= '0;
      wr_data_reg     <= OP_NOP;
      wr_en_reg       <= 1'b0;
      load_error_reg  <= 1'b0;
      prog_length_reg <= '0;
`ifdef BRACKET_CHECK_EN
      depth_reg       <= '0;
`endif
    end else begin
      // Every write is a single-cycle pulse unless re-armed below.
      wr_en_reg <= 1'b0;
      if (enter_clear) begin
        // The first clear write goes out together with the state change.
        wr_addr_reg    <= '0;
        wr_data_reg    <= OP_NOP;
        wr_en_reg      <= 1'b1;
        addr_cnt_reg   <= AW'(1);
        load_error_reg <= 1'b0;
`ifdef BRACKET_CHECK_EN
        depth_reg      <= '0;
`endif
      end else if (state_reg == ST_CLEAR) begin
        if (clear_done) begin
          addr_cnt_reg <= '0;
        end else begin
          wr_addr_reg  <= addr_cnt_reg;
          wr_data_reg  <= OP_NOP;
          wr_en_reg    <= 1'b1;
          addr_cnt_reg <= addr_cnt_reg + AW'(1);
        end
      end else if (state_reg == ST_LOAD) begin
        if (accept && op_valid) begin
          if (addr_cnt_reg == LAST_ADDR) begin
            load_error_reg <= 1'b1;
          end else begin
            wr_addr_reg  <= addr_cnt_reg;
            wr_data_reg  <= op_code;
            wr_en_reg    <= 1'b1;
            addr_cnt_reg <= addr_cnt_reg + AW'(1);
          end
`ifdef BRACKET_CHECK_EN
          if (op_code == OP_LOOP_OPEN) begin
            if (depth_reg != '1) depth_reg <= depth_reg + 10'd1;
          end else if (op_code == OP_LOOP_CLOSE) begin
            if (depth_reg == '0) load_error_reg <= 1'b1;
            else                 depth_reg      <= depth_reg - 10'd1;
          end
`endif
        end else if (is_term) begin
          prog_length_reg <= addr_cnt_reg;
        end
      end
    end
  end

  // RAM port mux: CPU passthrough only while running, loader otherwise
  always_comb begin
    if (state_reg == ST_RUN) begin
      prog_address_sig = cpu_prog_address;
      prog_data_sig    = cpu_prog_data;
      prog_wren_sig    = cpu_prog_wren;
      prog_rden_sig    = cpu_prog_rden;
    end else begin
      prog_address_sig = wr_addr_reg;
      prog_data_sig    = wr_data_reg;
      prog_wren_sig    = wr_en_reg;
      prog_rden_sig    = 1'b0;
    end
  end

endmodule

// File: tb/tb_prog_loader_arbiter.sv
// Directed bench for prog_loader_arbiter: clear sweep, loading, overflow,
// restart, CPU passthrough and asynchronous reset mid-load.
module tb_prog_loader_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] cpu_prog_address;
  logic [3:0] cpu_prog_data;
  logic       cpu_prog_wren;
  logic       cpu_prog_rden;
  logic [9:0] prog_address_sig;
  logic [3:0] prog_data_sig;
  logic       prog_wren_sig;
  logic       prog_rden_sig;
  logic       cpu_hold;
  logic       load_done;
  logic       load_error;
  logic [9:0] prog_length;

  int checks = 0;
  int errors = 0;

  logic [3:0]  mem_model [0:1023];
  logic [13:0] wlog [$];
  logic        last_hold;

  always #5 clk = ~clk;

  prog_loader_arbiter_if rx_if ();

  prog_loader_arbiter dut (
    .clk              (clk),
    .rst              (rst),
    .rx               (rx_if),
    .cpu_prog_address (cpu_prog_address),
    .cpu_prog_data    (cpu_prog_data),
    .cpu_prog_wren    (cpu_prog_wren),
    .cpu_prog_rden    (cpu_prog_rden),
    .prog_address_sig (prog_address_sig),
    .prog_data_sig    (prog_data_sig),
    .prog_wren_sig    (prog_wren_sig),
    .prog_rden_sig    (prog_rden_sig),
    .cpu_hold         (cpu_hold),
    .load_done        (load_done),
    .load_error       (load_error),
    .prog_length      (prog_length)
  );

  // RAM model: record every write seen on the bus mid-cycle
  always @(negedge clk) begin
    if (prog_wren_sig === 1'b1) begin
      mem_model[prog_address_sig] <= prog_data_sig;
      wlog.push_back({prog_address_sig, prog_data_sig});
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (rx_if.rx_ready !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (rx_if.rx_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wait_ready: rx_ready=%b, required 1 within 3000 cycles", rx_if.rx_ready);
    end
  endtask

  // One byte per cycle; returns at the negedge after the last acceptance.
  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      wait_ready();
      rx_if.rx_data  = s[i];
      rx_if.rx_valid = 1'b1;
      last_hold      = cpu_hold;
    end
    @(negedge clk);
    rx_if.rx_valid = 1'b0;
  endtask

  // Called at the negedge where the address-0 clear write should be visible.
  task automatic check_clear(input string tag);
    int bad = 0;
    int first_bad = -1;
    logic [9:0] bad_addr = '0;
    logic bad_wren = 1'b0;
    logic bad_ready = 1'b0;
    for (int k = 0; k < 1024; k++) begin
      if (k != 0) @(negedge clk);
      if (prog_wren_sig !== 1'b1 || prog_address_sig !== 10'(k) || prog_data_sig !== 4'd0 ||
          prog_rden_sig !== 1'b0 || rx_if.rx_ready !== 1'b0 || cpu_hold !== 1'b1 || load_done !== 1'b0) begin
        if (bad == 0) begin
          first_bad = k;
          bad_addr  = prog_address_sig;
          bad_wren  = prog_wren_sig;
          bad_ready = rx_if.rx_ready;
        end
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s clear_seq: %0d bad cycles, first at step %0d (addr=%0d wren=%b rx_ready=%b), required 0 bad",
               tag, bad, first_bad, bad_addr, bad_wren, bad_ready);
    end
    @(negedge clk);
    checks++;
    if (rx_if.rx_ready !== 1'b1) begin errors++; $display("FAIL %s clear_ready: rx_ready=%b required 1", tag, rx_if.rx_ready); end
    checks++;
    if (prog_wren_sig !== 1'b0) begin errors++; $display("FAIL %s clear_end_wren: wren=%b required 0", tag, prog_wren_sig); end
    checks++;
    if (cpu_hold !== 1'b1) begin errors++; $display("FAIL %s clear_hold: cpu_hold=%b required 1", tag, cpu_hold); end
    $display("clear sweep (%s) observed", tag);
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (prog_address_sig !== 10'd0) begin errors++; $display("FAIL reset_addr: %0d required 0", prog_address_sig); end
    checks++; if (prog_data_sig !== 4'd0) begin errors++; $display("FAIL reset_data: %0d required 0", prog_data_sig); end
    checks++; if (prog_wren_sig !== 1'b0) begin errors++; $display("FAIL reset_wren: %b required 0", prog_wren_sig); end
    checks++; if (prog_rden_sig !== 1'b0) begin errors++; $display("FAIL reset_rden: %b required 0", prog_rden_sig); end
    checks++; if (rx_if.rx_ready !== 1'b0) begin errors++; $display("FAIL reset_rx_ready: %b required 0", rx_if.rx_ready); end
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL reset_hold: %b required 1", cpu_hold); end
    checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL reset_done: %b required 0", load_done); end
    checks++; if (load_error !== 1'b0) begin errors++; $display("FAIL reset_error: %b required 0", load_error); end
    checks++; if (prog_length !== 10'd0) begin errors++; $display("FAIL reset_length: %0d required 0", prog_length); end
    $display("reset values observed");
  endtask

  task automatic test_clear();
    rst = 1'b1;
    @(negedge clk);
    check_clear("power_on");
  endtask

  task automatic test_load_basic();
    logic [13:0] exp_w [3];
    exp_w[0] = {10'd0, 4'd3};
    exp_w[1] = {10'd1, 4'd1};
    exp_w[2] = {10'd2, 4'd5};
    wlog.delete();
    send_str("+>.\n!");
    #1;
    checks++; if (wlog.size() != 3) begin errors++; $display("FAIL load_write_count: %0d required 3", wlog.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= wlog.size() || wlog[i] !== exp_w[i]) begin
        errors++;
        $display("FAIL load_write%0d: addr/data=%h required %h", i, (i < wlog.size()) ? wlog[i] : 14'h3fff, exp_w[i]);
      end
    end
    checks++; if (prog_length !== 10'd3) begin errors++; $display("FAIL load_length: %0d required 3", prog_length); end
    checks++; if (last_hold !== 1'b1) begin errors++; $display("FAIL load_hold_before_term: %b required 1", last_hold); end
    checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL load_hold_after_term: %b required 0", cpu_hold); end
    checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL load_done: %b required 1", load_done); end
    checks++; if (load_error !== 1'b0) begin errors++; $display("FAIL load_error: %b required 0", load_error); end
    // Zero-latency passthrough, sampled mid low phase
    cpu_prog_address = 10'h155; cpu_prog_data = 4'hA; cpu_prog_rden = 1'b1; cpu_prog_wren = 1'b0;
    #1;
    checks++; if (prog_address_sig !== 10'h155) begin errors++; $display("FAIL pass_addr1: %h required 155", prog_address_sig); end
    checks++; if (prog_data_sig !== 4'hA) begin errors++; $display("FAIL pass_data1: %h required a", prog_data_sig); end
    checks++; if (prog_rden_sig !== 1'b1) begin errors++; $display("FAIL pass_rden1: %b required 1", prog_rden_sig); end
    checks++; if (prog_wren_sig !== 1'b0) begin errors++; $display("FAIL pass_wren1: %b required 0", prog_wren_sig); end
    cpu_prog_address = 10'h2AA; cpu_prog_data = 4'h5; cpu_prog_rden = 1'b0; cpu_prog_wren = 1'b1;
    #1;
    checks++; if (prog_address_sig !== 10'h2AA) begin errors++; $display("FAIL pass_addr2: %h required 2aa", prog_address_sig); end
    checks++; if (prog_data_sig !== 4'h5) begin errors++; $display("FAIL pass_data2: %h required 5", prog_data_sig); end
    checks++; if (prog_wren_sig !== 1'b1) begin errors++; $display("FAIL pass_wren2: %b required 1", prog_wren_sig); end
    checks++; if (prog_rden_sig !== 1'b0) begin errors++; $display("FAIL pass_rden2: %b required 0", prog_rden_sig); end
    cpu_prog_wren = 1'b0; cpu_prog_rden = 1'b0; cpu_prog_address = '0; cpu_prog_data = '0;
    $display("load '+>.\\n!' and passthrough observed");
  endtask

  task automatic test_restart(input string tag, input logic exp_done, input logic exp_err_before);
    wlog.delete();
    send_str("x");
    #1;
    checks++; if (wlog.size() != 0) begin errors++; $display("FAIL %s drop_x_writes: %0d required 0", tag, wlog.size()); end
    checks++; if (load_done !== exp_done) begin errors++; $display("FAIL %s drop_x_done: %b required %b", tag, load_done, exp_done); end
    checks++; if (load_error !== exp_err_before) begin errors++; $display("FAIL %s drop_x_error: %b required %b", tag, load_error, exp_err_before); end
    send_str("@");
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL %s start_hold: %b required 1", tag, cpu_hold); end
    checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL %s start_done: %b required 0", tag, load_done); end
    checks++; if (load_error !== 1'b0) begin errors++; $display("FAIL %s start_error: %b required 0", tag, load_error); end
    check_clear(tag);
  endtask

  task automatic test_overflow();
    string s = "";
    int hit_top = 0;
    logic exp_done;
`ifdef BRACKET_CHECK_EN
    exp_done = 1'b0;
`else
    exp_done = 1'b1;
`endif
    for (int i = 0; i < 1030; i++) s = {s, "+"};
    s = {s, "!"};
    wlog.delete();
    send_str(s);
    #1;
    foreach (wlog[i]) if (wlog[i][13:4] == 10'd1023) hit_top++;
    checks++; if (wlog.size() != 1023) begin errors++; $display("FAIL ovf_write_count: %0d required 1023", wlog.size()); end
    checks++; if (hit_top != 0) begin errors++; $display("FAIL ovf_top_written: %0d writes to 1023 required 0", hit_top); end
    checks++; if (mem_model[1022] !== 4'd3) begin errors++; $display("FAIL ovf_mem1022: %0d required 3", mem_model[1022]); end
    checks++; if (mem_model[1023] !== 4'd0) begin errors++; $display("FAIL ovf_mem1023: %0d required 0", mem_model[1023]); end
    checks++; if (load_error !== 1'b1) begin errors++; $display("FAIL ovf_error: %b required 1", load_error); end
    checks++; if (prog_length !== 10'd1023) begin errors++; $display("FAIL ovf_length: %0d required 1023", prog_length); end
    checks++; if (load_done !== exp_done) begin errors++; $display("FAIL ovf_done: %b required %b", load_done, exp_done); end
    $display("overflow load of 1030 opcodes observed");
  endtask

`ifdef BRACKET_CHECK_EN
  task automatic test_bracket();
    send_str("[[+]!");
    #1;
    checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL brk_open_done: %b required 0", load_done); end
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL brk_open_hold: %b required 1", cpu_hold); end
    checks++; if (rx_if.rx_ready !== 1'b1) begin errors++; $display("FAIL brk_open_ready: %b required 1", rx_if.rx_ready); end
    checks++; if (load_error !== 1'b0) begin errors++; $display("FAIL brk_open_error: %b required 0", load_error); end
    send_str("@");
    send_str("]!");
    #1;
    checks++; if (load_error !== 1'b1) begin errors++; $display("FAIL brk_close_error: %b required 1", load_error); end
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL brk_close_hold: %b required 1", cpu_hold); end
    send_str("@");
    send_str("[+]!");
    #1;
    checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL brk_ok_done: %b required 1", load_done); end
    checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL brk_ok_hold: %b required 0", cpu_hold); end
    checks++; if (load_error !== 1'b0) begin errors++; $display("FAIL brk_ok_error: %b required 0", load_error); end
    checks++; if (prog_length !== 10'd3) begin errors++; $display("FAIL brk_ok_length: %0d required 3", prog_length); end
    $display("bracket checking observed");
  endtask
`endif

  task automatic test_async_reset();
    if (load_done === 1'b1) send_str("@");
    send_str("+-<>");
    // Write of '>' at address 3 is on the bus now; present byte 5.
    checks++; if (prog_wren_sig !== 1'b1 || prog_address_sig !== 10'd3) begin
      errors++; $display("FAIL arst_pre_write: wren=%b addr=%0d required 1/3", prog_wren_sig, prog_address_sig);
    end
    rx_if.rx_data  = 8'h2C;
    rx_if.rx_valid = 1'b1;
    #2 rst = 1'b0;
    #1;
    checks++; if (prog_wren_sig !== 1'b0) begin errors++; $display("FAIL arst_wren: %b required 0", prog_wren_sig); end
    checks++; if (prog_address_sig !== 10'd0) begin errors++; $display("FAIL arst_addr: %0d required 0", prog_address_sig); end
    checks++; if (prog_data_sig !== 4'd0) begin errors++; $display("FAIL arst_data: %0d required 0", prog_data_sig); end
    checks++; if (rx_if.rx_ready !== 1'b0) begin errors++; $display("FAIL arst_ready: %b required 0", rx_if.rx_ready); end
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL arst_hold: %b required 1", cpu_hold); end
    checks++; if (prog_length !== 10'd0) begin errors++; $display("FAIL arst_length: %0d required 0", prog_length); end
    rx_if.rx_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_clear("after_reset");
    send_str("-!");
    #1;
    checks++; if (prog_length !== 10'd1) begin errors++; $display("FAIL reload_length: %0d required 1", prog_length); end
    checks++; if (mem_model[0] !== 4'd4) begin errors++; $display("FAIL reload_mem0: %0d required 4", mem_model[0]); end
    checks++; if (mem_model[3] !== 4'd0) begin errors++; $display("FAIL reload_mem3: %0d required 0", mem_model[3]); end
    checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL reload_done: %b required 1", load_done); end
    $display("asynchronous reset mid-load observed");
  endtask

  initial begin
    rx_if.rx_data    = 8'h00;
    rx_if.rx_valid   = 1'b0;
    cpu_prog_address = '0;
    cpu_prog_data    = '0;
    cpu_prog_wren    = 1'b0;
    cpu_prog_rden    = 1'b0;
    last_hold        = 1'b0;
    test_reset();
    test_clear();
    test_load_basic();
    test_restart("restart_run", 1'b1, 1'b0);
    test_overflow();
`ifdef BRACKET_CHECK_EN
    test_restart("restart_ovf", 1'b0, 1'b1);
    test_bracket();
`else
    test_restart("restart_ovf", 1'b1, 1'b1);
`endif
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "time limit");
  end

endmodule
